sprite_fetch: RTL
=================

# sprite_fetch

Pixel-rate sprite fetch stage that sits directly upstream of the image `sram`. It converts the VGA scan position into a sprite-relative `sram` read address and drives the `sram` `en`/`addr` ports; the `sram` write-enable is tied low at the top level. It then consumes `sram` `data_o` one cycle later and emits a colour-keyed RGB pixel to the display mux. It also owns sprite position (double-buffered, applied at frame boundaries) and animation-frame sequencing.

## Interface
Parameters:
- `SPRITE_W`, 64: sprite width in pixels; power of two.
- `SPRITE_H`, 32: sprite height in pixels; power of two.
- `N_FRAMES`, 4: animation frames stored back to back in `sram`; power of two.
- `ADDR_WIDTH`, 13: must equal log2(`SPRITE_W`*`SPRITE_H`*`N_FRAMES`); matches the `sram` instance.
- `DATA_WIDTH`, 12: RGB444 pixel width; matches the `sram` instance.
- `KEY_COLOR`, 12'h0F0: transparent colour.
- `BG_COLOR`, 12'h000: colour output where there is no sprite or the pixel is transparent.
- `ANIM_DIV`, 8: number of video frames per animation step; ≥1.
- `INIT_X`, `INIT_Y`, 0: reset position.

Ports:
- `clk` in 1: system clock. All logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pixel_tick` in 1: one-cycle strobe per pixel; may be asserted on back-to-back cycles.
- `visible` in 1: scan position is inside the active area; sampled with `pixel_tick`.
- `pixel_x`, `pixel_y` in 10: scan position; sampled with `pixel_tick`.
- `frame_start` in 1: one-cycle pulse, once per video frame, outside the active area.
- `pos_valid` in 1: new-position request.
- `pos_x`, `pos_y` in 10: requested top-left corner.
- `pos_ready` out 1: pending-position slot is empty.
- `anim_en` in 1: animation advance enable.
- `sram_en` out 1: to `sram` `en`.
- `sram_addr` out `ADDR_WIDTH`: to `sram` `addr`.
- `sram_data` in `DATA_WIDTH`: from `sram` `data_o`.
- `rgb_out` out 12: pixel colour.
- `rgb_valid` out 1: one-cycle strobe marking `rgb_out` as a new pixel.

## Operation
- **Hit test** (stage 0, when `pixel_tick`=1):
  - hit = `visible` && `pixel_x` ≥ cur_x && `pixel_x` < cur_x+`SPRITE_W` && `pixel_y` ≥ cur_y && `pixel_y` < cur_y+`SPRITE_H`.
  - The sums are computed at 11 bits, so a sprite that straddles the right or bottom edge clips rather than wrapping.
- **Address**: {frame_idx, `pixel_y`−cur_y (log2 H bits), `pixel_x`−cur_x (log2 W bits)}, i.e. frame_idx·W·H + dy·W + dx.
- **Stage 1** (registered):
  - `sram_en` = `pixel_tick` && hit.
  - `sram_addr` takes the computed address when hit, otherwise holds its value.
  - Internal v1 = `pixel_tick` and h1 = hit are also registered.
- **Stage 2**: `sram` returns data at the end of stage 1. Internal v2 = v1 and h2 = h1.
- **Stage 3** (registered):
  - `rgb_valid` = v2.
  - `rgb_out` = (h2 && `sram_data` ≠ `KEY_COLOR`) ? `sram_data` : `BG_COLOR`. It is updated only when v2=1, otherwise it holds.
  - Non-hit pixels never read `sram`. Gating on h2 keeps stale `data_o` from being used.
- **Position handshake**:
  - A transfer occurs when `pos_valid` && `pos_ready`; it loads the pending register and `pos_ready` goes to 0.
  - On `frame_start` with a pending value already present before that edge: cur ← pending, and `pos_ready` returns to 1 on the next cycle.
  - A transfer on the same cycle as `frame_start` is not applied until the following `frame_start`.
  - cur_x/cur_y therefore never change mid-frame.
- **Animation**:
  - anim_cnt increments on `frame_start` when `anim_en`=1.
  - When anim_cnt reaches `ANIM_DIV`−1, it clears and frame_idx ← frame_idx+1 mod `N_FRAMES` (natural wrap).
  - When `anim_en`=0, anim_cnt and frame_idx hold.
  - frame_idx changes only at `frame_start`.

## Timing
- Latency: a `pixel_tick` in cycle T gives `sram_en`/`sram_addr` valid in T+1 and `rgb_out`/`rgb_valid` in T+3. Throughput is 1 pixel per cycle.
- Reset values:
  - `sram_en`=0, `sram_addr`=0, `rgb_out`=`BG_COLOR`, `rgb_valid`=0, `pos_ready`=1.
  - cur=(`INIT_X`,`INIT_Y`), no pending position, anim_cnt=0, frame_idx=0, pipeline valids=0.
- Reset mid-operation: all in-flight pixels are dropped and no `rgb_valid` is emitted for them. Reset assertion takes effect without waiting for a `clk` edge.
- `sram_en` is never asserted when `pixel_tick` was 0 in the previous cycle.

## Test plan
- **Reset then scan**: cur=(0,0), sram preloaded with addr a → data a. Tick at (5,3) → in T+1 `sram_en`=1 and `sram_addr`=3·64+5=197; in T+3 `rgb_valid`=1 and `rgb_out`=197 (12'h0C5).
- **Miss and key**:
  - Tick at (64,0) → `sram_en` stays 0; T+3 gives `rgb_out`=12'h000 with `rgb_valid`=1.
  - Tick at a hit where the stored value is 12'h0F0 → `rgb_out`=12'h000.
- **Position handshake**: `pos_valid` with (100,50) → `pos_ready` falls. Tick at (100,50) before `frame_start` → miss. After `frame_start`, tick at (100,50) → addr 0, and `pos_ready`=1 one cycle later.
- **Simultaneous transfer and `frame_start`**: the new position is applied only at the second `frame_start`.
- **Animation wrap**: `anim_en`=1 with `ANIM_DIV`=8. After 8 `frame_start` pulses, tick at (0,0) → addr 2048. After 32 pulses → addr 0.
- **Back-to-back ticks and reset mid-pipeline**:
  - Ticks on 4 consecutive cycles at x=0..3 → `rgb_out` is 0,1,2,3 on consecutive cycles.
  - Asserting `reset_n`=0 one cycle after the ticks → no further `rgb_valid`.

Source files
------------

// File: rtl/sprite_fetch.sv
// Sprite fetch stage: scan position -> sprite sram address -> colour-keyed pixel.
// Owns double-buffered sprite position and animation frame sequencing.
module sprite_fetch #(
    parameter int          SPRITE_W   = 64,
    parameter int          SPRITE_H   = 32,
    parameter int          N_FRAMES   = 4,
    parameter int          ADDR_WIDTH = 13,
    parameter int          DATA_WIDTH = 12,
    parameter logic [11:0] KEY_COLOR  = 12'h0F0,
    parameter logic [11:0] BG_COLOR   = 12'h000,
    parameter int          ANIM_DIV   = 8,
    parameter int          INIT_X     = 0,
    parameter int          INIT_Y     = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pixel_tick,
    input  logic                  visible,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    input  logic                  frame_start,
    input  logic                  pos_valid,
    input  logic [9:0]            pos_x,
    input  logic [9:0]            pos_y,
    output logic                  pos_ready,
    input  logic                  anim_en,
    output logic                  sram_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data,
    output logic [11:0]           rgb_out,
    output logic                  rgb_valid
);

    localparam int LW = $clog2(SPRITE_W);
    localparam int LH = $clog2(SPRITE_H);
    localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [9:0]            r_cur_x;
    logic [9:0]            r_cur_y;
    logic [9:0]            r_pend_x;
    logic [9:0]            r_pend_y;
    logic                  r_pend_full;
    logic [CW-1:0]         r_anim_cnt;
    logic [FW-1:0]         r_frame_idx;
    logic                  r_sram_en;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic                  r_v1;
    logic                  r_h1;
    logic                  r_v2;
    logic                  r_h2;
    logic                  r_rgb_valid;
    logic [11:0]           r_rgb_out;

    logic [10:0]           w_x_end;
    logic [10:0]           w_y_end;
    logic                  w_hit;
    logic [9:0]            w_dx;
    logic [9:0]            w_dy;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_fbase;
    logic                  w_xfer;
    logic                  w_key;

    // 11-bit bounds so a sprite near the right/bottom edge clips, never wraps
    assign w_x_end = {1'b0, r_cur_x} + 11'(SPRITE_W);
    assign w_y_end = {1'b0, r_cur_y} + 11'(SPRITE_H);

    assign w_hit = visible
                && ({1'b0, pixel_x} >= {1'b0, r_cur_x})
                && ({1'b0, pixel_x} <  w_x_end)
                && ({1'b0, pixel_y} >= {1'b0, r_cur_y})
                && ({1'b0, pixel_y} <  w_y_end);

    assign w_dx = pixel_x - r_cur_x;
    assign w_dy = pixel_y - r_cur_y;

    always_comb begin
        w_fbase = '0;
        if (N_FRAMES > 1) begin
            w_fbase = ADDR_WIDTH'(r_frame_idx) << (LW + LH);
        end
        w_addr = w_fbase
               | (ADDR_WIDTH'(w_dy[LH-1:0]) << LW)
               | ADDR_WIDTH'(w_dx[LW-1:0]);
    end

    assign w_xfer = pos_valid && !r_pend_full;
    assign w_key  = (sram_data == DATA_WIDTH'(KEY_COLOR));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_x     <= 10'(INIT_X);
            r_cur_y     <= 10'(INIT_Y);
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_pend_full <= 1'b0;
        end else begin
            // pending slot is only committed if it was filled before this edge
            if (frame_start && r_pend_full) begin
                r_cur_x     <= r_pend_x;
                r_cur_y     <= r_pend_y;
                r_pend_full <= 1'b0;
            end
            if (w_xfer) begin
                r_pend_x    <= pos_x;
                r_pend_y    <= pos_y;
                r_pend_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_anim_cnt  <= '0;
            r_frame_idx <= '0;
        end else if (frame_start && anim_en) begin
            if (r_anim_cnt == CW'(ANIM_DIV - 1)) begin
                r_anim_cnt  <= '0;
                r_frame_idx <= (N_FRAMES > 1) ? r_frame_idx + FW'(1) : '0;
            end else begin
                r_anim_cnt  <= r_anim_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sram_en   <= 1'b0;
            r_sram_addr <= '0;
            r_v1        <= 1'b0;
            r_h1        <= 1'b0;
            r_v2        <= 1'b0;
            r_h2        <= 1'b0;
        end else begin
            r_sram_en <= pixel_tick && w_hit;
            if (pixel_tick && w_hit) begin
                r_sram_addr <= w_addr;
            end
            r_v1 <= pixel_tick;
            r_h1 <= w_hit;
            r_v2 <= r_v1;
            r_h2 <= r_h1;
        end
    end

    // h2 gating keeps stale sram data out of non-hit pixels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb_valid <= 1'b0;
            r_rgb_out   <= BG_COLOR;
        end else begin
            r_rgb_valid <= r_v2;
            if (r_v2) begin
                r_rgb_out <= (r_h2 && !w_key) ? 12'(sram_data) : BG_COLOR;
            end
        end
    end

    assign pos_ready = !r_pend_full;
    assign sram_en   = r_sram_en;
    assign sram_addr = r_sram_addr;
    assign rgb_out   = r_rgb_out;
    assign rgb_valid = r_rgb_valid;

endmodule
